dct_coef_accum: RTL and testbench
=================================

DCT_COEF_ACCUM -- requirements
Module: dct_coef_accum

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 8: number of fractional bits in cos_term.
REQ-002 SHALL have parameter LEVEL_SHIFT, default 1: when 1, subtract 128 from each pixel before multiplying.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request one coefficient computation.
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have ports n1 and n2, output, 3 bits each: sample index driven to the combinational cosine LUT.
REQ-008 SHALL have port cos_term, input, 32 bits: signed fixed-point term returned by the LUT for the current n1/n2, same cycle.
REQ-009 SHALL have port pix_addr, output, 6 bits: equals {n1,n2}, the block-buffer read address.
REQ-010 SHALL have port pix_data, input, 8 bits: unsigned pixel from a synchronous-read buffer, valid one cycle after pix_addr is sampled.
REQ-011 SHALL have port coef, output, 32 bits: signed rounded coefficient.
REQ-012 SHALL have port coef_valid, output, 1 bit: coef holds a result.
REQ-013 SHALL have port coef_ready, input, 1 bit: consumer accepts coef.

Function
REQ-014 SHALL implement the states IDLE, RUN, DRAIN and OUT.
REQ-015 In IDLE, start=1 SHALL clear the accumulator, set the index to 0 and enter RUN; otherwise the block stays in IDLE.
REQ-016 In RUN, the block SHALL issue one index per cycle, 0..63, with n1 = index[5:3] and n2 = index[2:0] (row-major order).
REQ-017 After index 63 is issued, the block SHALL enter DRAIN; n1/n2/pix_addr then hold 0.
REQ-018 For each index, cos_term SHALL be registered in the cycle it is issued and paired with the pix_data returned in the next cycle.
REQ-019 The pixel operand SHALL be 9-bit signed: pix_data-128 when LEVEL_SHIFT=1, else zero-extended pix_data.
REQ-020 Each product SHALL be 41-bit signed (9 x 32 bits), truncated to 32 bits and added to a 32-bit signed accumulator.
REQ-021 DRAIN SHALL last 2 cycles: the first accumulates the index-63 product, the second computes coef.
REQ-022 The coef computation SHALL be (acc + 2^(FRAC_BITS-1)) arithmetically shifted right by FRAC_BITS (round half up).
REQ-023 After DRAIN the block SHALL enter OUT with coef_valid=1 and coef registered.
REQ-024 coef_valid SHALL rise on the 66th rising edge after the edge that sampled start.
REQ-025 In OUT, coef and coef_valid SHALL hold stable while coef_ready=0.
REQ-026 When coef_ready=1 in OUT, the block SHALL return to IDLE next edge, clearing coef_valid; coef retains its value.
REQ-027 start while busy=1 SHALL be ignored, with no queuing.
REQ-028 start high in the same cycle as the OUT-to-IDLE handshake SHALL be ignored; start is only sampled in IDLE.
REQ-029 Accumulation SHALL wrap at 32 bits with no saturation; for legal inputs, |acc| < 2^22.

Reset
REQ-030 rst_n low SHALL force IDLE asynchronously and clear busy, n1, n2, pix_addr, coef, coef_valid, the accumulator and the index to 0, from any state including mid-RUN.
REQ-031 After rst_n deasserts, the first start SHALL produce a result identical to one from a fresh power-up.

Verification
REQ-032 All pixels 128, LEVEL_SHIFT=1, model LUT returning any values -> coef=0, coef_valid at edge 66.
REQ-033 Pixel (0,1)=255, all others 128, model cos_term(0,1)=-48 -> acc=-6096, coef=-24 (0xFFFFFFE8).
REQ-034 Result ready, coef_ready held low 10 cycles then pulsed -> coef_valid stays high and coef stable for 10 cycles, then drops one edge after the pulse, busy=0.
REQ-035 start pulsed again at index 20 of a run -> result unchanged, exactly one coef_valid rise.
REQ-036 rst_n pulsed low at index 30 -> all outputs 0 immediately; a new start then reproduces the REQ-033 value exactly.

Source files
------------

// File: rtl/dct_coef_accum.sv
// One 2-D DCT coefficient: walks an 8x8 block in row-major order, multiply-accumulates
// level-shifted pixels against LUT cosine terms, then rounds and presents the result.
module dct_coef_accum #(
    parameter int FRAC_BITS   = 8,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic [2:0]         n1,
    output logic [2:0]         n2,
    input  logic signed [31:0] cos_term,
    output logic [5:0]         pix_addr,
    input  logic [7:0]         pix_data,
    output logic signed [31:0] coef,
    output logic               coef_valid,
    input  logic               coef_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

    localparam logic signed [31:0] ROUND = (32'sd1 <<< FRAC_BITS) >>> 1;

    state_e             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic               drain_q, drain_d;
    logic               prod_vld_q, prod_vld_d;
    logic signed [31:0] cos_q, cos_d;
    logic signed [31:0] acc_q, acc_d;
    logic signed [31:0] coef_q, coef_d;

    logic signed [8:0]  pix_s;
    logic signed [40:0] pix_ext, cos_ext, prod;
    logic signed [31:0] rnd_sum;

    always_comb begin
        pix_s   = (LEVEL_SHIFT != 0) ? $signed({1'b0, pix_data}) - 9'sd128
                                     : $signed({1'b0, pix_data});
        pix_ext = {{32{pix_s[8]}}, pix_s};
        cos_ext = {{9{cos_q[31]}}, cos_q};
        prod    = pix_ext * cos_ext;
        rnd_sum = acc_q + ROUND;
    end

    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        drain_d    = drain_q;
        prod_vld_d = 1'b0;
        cos_d      = cos_q;
        coef_d     = coef_q;
        acc_d      = prod_vld_q ? acc_q + prod[31:0] : acc_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // cos_term is captured now; its pixel arrives from the buffer next cycle
                cos_d      = cos_term;
                prod_vld_d = 1'b1;
                idx_d      = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    drain_d = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else begin
                    drain_d = 1'b0;
                    coef_d  = rnd_sum >>> FRAC_BITS;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (coef_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            drain_q    <= 1'b0;
            prod_vld_q <= 1'b0;
            cos_q      <= '0;
            acc_q      <= '0;
            coef_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            drain_q    <= drain_d;
            prod_vld_q <= prod_vld_d;
            cos_q      <= cos_d;
            acc_q      <= acc_d;
            coef_q     <= coef_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign coef_valid = (state_q == OUT);
    assign n1         = (state_q == RUN) ? idx_q[5:3] : 3'd0;
    assign n2         = (state_q == RUN) ? idx_q[2:0] : 3'd0;
    assign pix_addr   = {n1, n2};
    assign coef       = coef_q;

endmodule

// File: tb/tb_dct_coef_accum.sv
// Directed bench for dct_coef_accum with a combinational cosine LUT model and a
// synchronous-read pixel buffer model.
module tb_dct_coef_accum;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               busy;
    logic [2:0]         n1, n2;
    logic signed [31:0] cos_term;
    logic [5:0]         pix_addr;
    logic [7:0]         pix_data;
    logic signed [31:0] coef;
    logic               coef_valid;
    logic               coef_ready = 1'b0;

    logic signed [31:0] cos_lut [64];
    logic [7:0]         mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign cos_term = cos_lut[{n1, n2}];
    always @(posedge clk) pix_data <= mem[pix_addr];

    dct_coef_accum #(.FRAC_BITS(8), .LEVEL_SHIFT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .n1(n1), .n2(n2), .cos_term(cos_term), .pix_addr(pix_addr),
        .pix_data(pix_data), .coef(coef), .coef_valid(coef_valid),
        .coef_ready(coef_ready)
    );

    task automatic fill_block();
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 8'd128;
            cos_lut[i] = 32'(i * 37 - 1000);
        end
    endtask

    // Pulses start for one edge; returns #1 after the sampling edge.
    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!coef_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        coef_ready = 1'b1;
        @(posedge clk);
        #1;
        coef_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, n1, n2, pix_addr, coef_valid} !== 14'd0 || coef !== 32'sd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b n1=%0d n2=%0d addr=%0d valid=%b coef=%0d, want all 0",
                     busy, n1, n2, pix_addr, coef_valid, coef);
        end
    endtask

    task automatic test_all_mid_grey();
        int edges;
        fill_block();
        start_run();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL grey_busy: busy=%b want 1", busy);
        end
        wait_valid(edges);
        checks++;
        if (edges !== 66) begin
            errors++;
            $display("FAIL grey_latency: valid after %0d edges, want 66", edges);
        end
        checks++;
        if (coef !== 32'sd0) begin
            errors++;
            $display("FAIL grey_coef: coef=%0d want 0", coef);
        end
        handshake();
    endtask

    task automatic test_single_pixel();
        int edges;
        fill_block();
        mem[1]     = 8'd255;
        cos_lut[1] = -32'sd48;
        start_run();
        wait_valid(edges);
        checks++;
        if (edges !== 66 || coef !== 32'hFFFF_FFE8) begin
            errors++;
            $display("FAIL single_pixel: edges=%0d coef=%h, want 66 / ffffffe8", edges, coef);
        end
        handshake();
    endtask

    // Pixel (0,0): 72*100=7200; pixel (7,7): -128*256=-32768; acc=-25568 -> -100.
    task automatic test_corners();
        int edges;
        fill_block();
        mem[0]      = 8'd200;
        cos_lut[0]  = 32'sd100;
        mem[63]     = 8'd0;
        cos_lut[63] = 32'sd256;
        start_run();
        wait_valid(edges);
        checks++;
        if (coef !== -32'sd100) begin
            errors++;
            $display("FAIL corners: coef=%0d want -100", coef);
        end
        handshake();
    endtask

    // acc=+128 rounds up to 1; acc=-128 rounds up to 0.
    task automatic test_round_half();
        int edges;
        fill_block();
        mem[28]     = 8'd129;
        cos_lut[28] = 32'sd128;
        start_run();
        wait_valid(edges);
        checks++;
        if (coef !== 32'sd1) begin
            errors++;
            $display("FAIL round_pos_half: coef=%0d want 1", coef);
        end
        handshake();
        fill_block();
        mem[45]     = 8'd127;
        cos_lut[45] = 32'sd128;
        start_run();
        wait_valid(edges);
        checks++;
        if (coef !== 32'sd0) begin
            errors++;
            $display("FAIL round_neg_half: coef=%0d want 0", coef);
        end
        handshake();
    endtask

    task automatic test_handshake();
        int edges;
        logic signed [31:0] held;
        fill_block();
        mem[1]     = 8'd255;
        cos_lut[1] = -32'sd48;
        start_run();
        wait_valid(edges);
        held = -32'sd24;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (coef_valid !== 1'b1 || coef !== held || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b busy=%b coef=%0d, want 1/1/%0d",
                         i, coef_valid, busy, coef, held);
            end
        end
        // start raised together with the accepting ready must not launch a run
        @(negedge clk);
        coef_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        coef_ready = 1'b0;
        start      = 1'b0;
        checks++;
        if (coef_valid !== 1'b0 || busy !== 1'b0 || coef !== held) begin
            errors++;
            $display("FAIL release: valid=%b busy=%b coef=%0d, want 0/0/%0d",
                     coef_valid, busy, coef, held);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_handshake: busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int rises;
        int cyc;
        fill_block();
        mem[1]     = 8'd255;
        cos_lut[1] = -32'sd48;
        start_run();
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (n1 !== 3'd2 || n2 !== 3'd4 || pix_addr !== 6'd20) begin
            errors++;
            $display("FAIL index20: n1=%0d n2=%0d addr=%0d, want 2/4/20", n1, n2, pix_addr);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rises = 0;
        cyc   = 21;
        while (!coef_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 65) begin
                checks++;
                if (pix_addr !== 6'd0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_addr: addr=%0d busy=%b, want 0/1", pix_addr, busy);
                end
            end
        end
        checks++;
        if (cyc !== 66 || coef !== -32'sd24) begin
            errors++;
            $display("FAIL start_ignored: edges=%0d coef=%0d, want 66 / -24", cyc, coef);
        end
        handshake();
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (coef_valid) rises++;
        end
        checks++;
        if (rises !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_queue: extra valid cycles=%0d busy=%b, want 0/0", rises, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int edges;
        fill_block();
        mem[1]     = 8'd255;
        cos_lut[1] = -32'sd48;
        start_run();
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, n1, n2, pix_addr, coef_valid} !== 14'd0 || coef !== 32'sd0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b n1=%0d n2=%0d addr=%0d valid=%b coef=%0d, want all 0",
                     busy, n1, n2, pix_addr, coef_valid, coef);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_run();
        wait_valid(edges);
        checks++;
        if (edges !== 66 || coef !== 32'hFFFF_FFE8) begin
            errors++;
            $display("FAIL after_reset: edges=%0d coef=%h, want 66 / ffffffe8", edges, coef);
        end
        handshake();
    endtask

    initial begin
        fill_block();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_all_mid_grey();
        test_single_pixel();
        test_corners();
        test_round_half();
        test_handshake();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
